ahb_apb_bridge_ctrl: RTL

AHB_APB_BRIDGE_CTRL -- requirements
Module: ahb_apb_bridge_ctrl

---
 rtl/ahb_apb_bridge_ctrl_pkg.sv | 36 +++
 rtl/ahb_apb_bridge_ctrl_if.sv | 55 +++++
 rtl/ahb_apb_bridge_ctrl_strb.sv | 36 +++
 rtl/ahb_apb_bridge_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_bridge_ctrl_pkg.sv
// Shared definitions for the AHB-lite to APB bridge: FSM state encoding,
// AHB transfer/size codes and small helpers used by the bridge datapath.
package ahb_apb_pkg;

  localparam int DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // The APB segment is 32 bits wide, so anything wider than a word is refused.
  function automatic logic hsize_supported(input logic [2:0] hsize);
    return (hsize <= HSIZE_WORD);
  endfunction

  // AHB HPROT[0] is data/opcode, HPROT[1] is privileged; APB PPROT[2] is
  // instruction, PPROT[1] non-secure (always secure here), PPROT[0] privileged.
  function automatic logic [2:0] ahb_to_pprot(input logic [1:0] hprot_lo);
    return {~hprot_lo[0], 1'b0, hprot_lo[1]};
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_ctrl_if.sv
// Bus bundles for the bridge: AHB-lite slave side and APB master side.
interface ahbif #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  logic          hreadym;
  logic          hready;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic          hruser;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hreadym,
    output hready, hresp, hrdata, hruser
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hreadym,
    input  hready, hresp, hrdata, hruser
  );
endinterface

interface apbif #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [2:0]    pprot;
  logic [3:0]    pstrb;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic          apbactive;

  modport master (
    output psel, penable, paddr, pwrite, pprot, pstrb, pwdata, apbactive,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pprot, pstrb, pwdata, apbactive,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahb_apb_bridge_ctrl_strb.sv
// Byte-lane strobe generator: maps an AHB transfer size and the low address
// bits onto the four APB write strobes of a 32-bit lane.
module ahb_apb_strb
  import ahb_apb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o
);

  // Decode size/offset into the active byte lanes; unsupported sizes get none.
  always_comb begin
    strb_o = 4'b0000;
    case (hsize_i)
      HSIZE_BYTE: begin
        case (addr_i)
          2'b00:   strb_o = 4'b0001;
          2'b01:   strb_o = 4'b0010;
          2'b10:   strb_o = 4'b0100;
          2'b11:   strb_o = 4'b1000;
          default: strb_o = 4'b0000;
        endcase
      end
      HSIZE_HALF: begin
        if (addr_i[1]) begin
          strb_o = 4'b1100;
        end else begin
          strb_o = 4'b0011;
        end
      end
      HSIZE_WORD: strb_o = 4'b1111;
      default:    strb_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-lite slave to single-segment APB master bridge. Each accepted AHB
// transfer becomes one APB SETUP/ACCESS pair; writes spend one extra cycle
// collecting HWDATA. Oversized transfers and PSLVERR become a two-cycle
// AHB ERROR response. All bus-facing outputs come straight from flops.
module ahb_apb_bridge_ctrl
  import ahb_apb_pkg::*;
#(
  parameter int PAW = 16,
  parameter int AW  = 32
) (
  input  logic  clk,
  input  logic  resetn,
  ahbif.slave   ahbs,
  apbif.master  apbm
);

  bridge_state_e state_q, state_d;

  logic          hready_q, hready_d;
  logic          hresp_q, hresp_d;
  logic [DW-1:0] hrdata_q, hrdata_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          apbactive_q, apbactive_d;

  logic [PAW-1:0] paddr_q;
  logic           pwrite_q;
  logic [2:0]     pprot_q;
  logic [3:0]     pstrb_q;
  logic [DW-1:0]  pwdata_q;

  logic       accept_s;
  logic       load_addr_s;
  logic       load_wdata_s;
  logic [3:0] strb_s;
  logic       bus_unused_s;

  // Upper address bits and cacheable/bufferable HPROT bits have no APB meaning.
  assign bus_unused_s = ^{ahbs.haddr[AW-1:PAW], ahbs.hprot[3:2]};

  ahb_apb_strb u_strb (
    .hsize_i (ahbs.hsize),
    .addr_i  (ahbs.haddr[1:0]),
    .strb_o  (strb_s)
  );

  // A new address phase is taken only when the bridge is free to respond.
  always_comb begin
    accept_s = 1'b0;
    if ((state_q == ST_IDLE) || (state_q == ST_ERR2)) begin
      accept_s = ahbs.hsel & ahbs.hreadym & ahbs.htrans[1] & hready_q;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state and next-output decode for the bridge sequencer.
  always_comb begin
    state_d      = state_q;
    hready_d     = hready_q;
    hresp_d      = hresp_q;
    hrdata_d     = hrdata_q;
    load_addr_s  = 1'b0;
    load_wdata_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept_s) begin
          load_addr_s = 1'b1;
          hready_d    = 1'b0;
          if (!hsize_supported(ahbs.hsize)) begin
            state_d = ST_ERR1;
            hresp_d = 1'b1;
          end else if (ahbs.hwrite) begin
            state_d = ST_WDATA;
            hresp_d = 1'b0;
          end else begin
            state_d = ST_SETUP;
            hresp_d = 1'b0;
          end
        end else begin
          state_d  = ST_IDLE;
          hready_d = 1'b1;
          hresp_d  = 1'b0;
        end
      end
      ST_WDATA: begin
        load_wdata_s = 1'b1;
        state_d      = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apbm.pready) begin
          if (apbm.pslverr) begin
            state_d  = ST_ERR1;
            hready_d = 1'b0;
            hresp_d  = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            hready_d = 1'b1;
            hresp_d  = 1'b0;
            if (!pwrite_q) begin
              hrdata_d = apbm.prdata;
            end else begin
              hrdata_d = hrdata_q;
            end
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_ERR1: begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = 1'b0;
      end
    endcase
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    apbactive_d = (state_d == ST_WDATA) || (state_d == ST_SETUP) || (state_d == ST_ACCESS);
  end

  // Sequencer state and AHB/APB handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      hready_q    <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= {DW{1'b0}};
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      apbactive_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hready_q    <= hready_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      apbactive_q <= apbactive_d;
    end
  end

  // Address-phase capture; held untouched until the next accepted transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      paddr_q  <= {PAW{1'b0}};
      pwrite_q <= 1'b0;
      pprot_q  <= 3'b000;
      pstrb_q  <= 4'b0000;
    end else if (load_addr_s) begin
      paddr_q  <= ahbs.haddr[PAW-1:0];
      pwrite_q <= ahbs.hwrite;
      pprot_q  <= ahb_to_pprot(ahbs.hprot[1:0]);
      pstrb_q  <= ahbs.hwrite ? strb_s : 4'b0000;
    end else begin
      paddr_q  <= paddr_q;
      pwrite_q <= pwrite_q;
      pprot_q  <= pprot_q;
      pstrb_q  <= pstrb_q;
    end
  end

  // Write data arrives one cycle after the address phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwdata_q <= {DW{1'b0}};
    end else if (load_wdata_s) begin
      pwdata_q <= ahbs.hwdata;
    end else begin
      pwdata_q <= pwdata_q;
    end
  end

  assign ahbs.hready    = hready_q;
  assign ahbs.hresp     = hresp_q;
  assign ahbs.hrdata    = hrdata_q;
  assign ahbs.hruser    = 1'b0;

  assign apbm.psel      = psel_q;
  assign apbm.penable   = penable_q;
  assign apbm.paddr     = paddr_q;
  assign apbm.pwrite    = pwrite_q;
  assign apbm.pprot     = pprot_q;
  assign apbm.pstrb     = pstrb_q;
  assign apbm.pwdata    = pwdata_q;
  assign apbm.apbactive = apbactive_q;

endmodule
